// File: rtl/fll_controller_param_if.sv
// Control/status bundle between the FLL controller and its host.
// The host drives the reference and mode controls; the controller returns trim and status.
interface fll_controller_param_if #(
  parameter int TRIM_W = 26,
  parameter int CODE_W = 5,
  parameter int DIV_W  = 5
) ();
  logic              enable;
  logic              hold;
  logic              osc;
  logic [DIV_W-1:0]  div;
  logic [TRIM_W-1:0] trim;
  logic [CODE_W-1:0] code;
  logic              locked;
  logic [1:0]        state;
  logic              osc_lost;

  modport master (
    output enable, hold, osc, div,
    input  trim, code, locked, state, osc_lost
  );

  modport slave (
    input  enable, hold, osc, div,
    output trim, code, locked, state, osc_lost
  );
endinterface

// File: rtl/fll_controller_param.sv
// Frequency-locked-loop controller: counts DCO clocks per reference period and steps a thermometer trim.
// Defining FLL_OSC_LOSS_EN enables reference-loss detection on counter saturation.
module fll_controller_param #(
  parameter int TRIM_W      = 26,
  parameter int CODE_W      = 5,
  parameter int DIV_W       = 5,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TOL         = 0,
  parameter int ACQ_STEP    = 4,
  parameter int ACQ_THRESH  = 2,
  parameter int LOCK_COUNT  = 8,
  parameter int INIT_CODE   = 0
) (
  input logic                  clock,
  input logic                  reset,
  fll_controller_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int                   LC_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [LC_W-1:0]      LOCK_MAX = LC_W'(LOCK_COUNT);
  localparam logic [CODE_W-1:0]    INIT     = CODE_W'(INIT_CODE);
  localparam logic signed [CNT_W:0] TOL_S   = (CNT_W+1)'(TOL);
  localparam logic signed [CNT_W:0] THR_S   = (CNT_W+1)'(ACQ_THRESH);

  function automatic logic [TRIM_W-1:0] therm(input logic [CODE_W-1:0] c);
    logic [TRIM_W-1:0] t;
    for (int i = 0; i < TRIM_W; i++) t[i] = (CODE_W'(i) < c);
    return t;
  endfunction

  // Saturating step toward either end of the trim range; never wraps.
  function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] c,
                                                  input int step, input logic up);
    int t;
    t = up ? int'(c) + step : int'(c) - step;
    if (t > TRIM_W) t = TRIM_W;
    if (t < 0) t = 0;
    return CODE_W'(t);
  endfunction

  localparam logic [TRIM_W-1:0] TRIM_INIT = therm(INIT);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   osc_edge;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  state_t                 state_reg, state_next;
  logic [CODE_W-1:0]      code_reg, code_next;
  logic [TRIM_W-1:0]      trim_reg, trim_next;
  logic [LC_W-1:0]        lock_cnt_reg, lock_cnt_next;
  logic                   locked_reg, locked_next;
  logic                   first_reg, first_next;
  logic                   lost_reg, lost_next;
  logic signed [CNT_W:0]  err, abs_err;

  assign osc_edge = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign cnt_next = osc_edge ? CNT_W'(1) : ((cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1);

  // cnt_reg on the edge cycle is the measured period.
  assign err     = $signed({1'b0, cnt_reg}) - $signed({{(CNT_W+1-DIV_W){1'b0}}, bus.div});
  assign abs_err = err[CNT_W] ? -err : err;

`ifdef FLL_OSC_LOSS_EN
  assign lost_next = osc_edge ? 1'b0 : ((cnt_reg == CNT_MAX) ? 1'b1 : lost_reg);
`else
  assign lost_next = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < TRIM_W; gi++) begin : g_therm
      assign trim_next[gi] = (CODE_W'(gi) < code_next);
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    lock_cnt_next = lock_cnt_reg;
    locked_next   = locked_reg;
    first_next    = first_reg;

    if (!bus.enable) begin
      state_next    = IDLE;
      code_next     = INIT;
      lock_cnt_next = '0;
      locked_next   = 1'b0;
      first_next    = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = ACQUIRE;
          first_next = 1'b1;
        end
        HOLD: begin
          if (!bus.hold) state_next = TRACK;
        end
        default: begin
          if (bus.hold) begin
            state_next = HOLD;
          end else if (osc_edge) begin
            // A restarted count (after IDLE or reference loss) gives no valid period.
            if (first_reg || lost_reg) begin
              first_next = 1'b0;
            end else if (bus.div == '0) begin
              lock_cnt_next = '0;
            end else if (abs_err <= TOL_S) begin
              if (lock_cnt_reg != LOCK_MAX) lock_cnt_next = lock_cnt_reg + 1'b1;
              locked_next = (lock_cnt_next == LOCK_MAX);
              if (state_reg == ACQUIRE) state_next = TRACK;
            end else begin
              code_next     = step_code(code_reg, (state_reg == ACQUIRE) ? ACQ_STEP : 1,
                                        ~err[CNT_W]);
              lock_cnt_next = '0;
              locked_next   = 1'b0;
              if (state_reg == TRACK && abs_err > THR_S) state_next = ACQUIRE;
            end
          end
        end
      endcase
    end

    if (bus.div == '0 || lost_next) begin
      locked_next   = 1'b0;
      lock_cnt_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg     <= '0;
      prev_reg     <= 1'b0;
      cnt_reg      <= '0;
      state_reg    <= IDLE;
      code_reg     <= INIT;
      trim_reg     <= TRIM_INIT;
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
      first_reg    <= 1'b1;
      lost_reg     <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], bus.osc};
      prev_reg     <= sync_reg[SYNC_STAGES-1];
      cnt_reg      <= cnt_next;
      state_reg    <= state_next;
      code_reg     <= code_next;
      trim_reg     <= trim_next;
      lock_cnt_reg <= lock_cnt_next;
      locked_reg   <= locked_next;
      first_reg    <= first_next;
      lost_reg     <= lost_next;
    end
  end

  assign bus.trim     = trim_reg;
  assign bus.code     = code_reg;
  assign bus.locked   = locked_reg;
  assign bus.state    = state_reg;
  assign bus.osc_lost = lost_reg;

endmodule

// File: doc/fll_controller_param.md
Name: fll_controller_param

Overview:
Parametrised frequency-locked-loop controller, successor to the fixed 26-bit/5-bit DLL controller. Runs on the ring-oscillator output clock and counts its cycles per period of the external reference osc. It steps a thermometer trim word so the ratio matches div. Adds tolerance window, two-speed acquisition, lock detect, hold mode and status outputs.

Parameters:
TRIM_W, 26, thermometer trim width driven to the ring oscillator
CODE_W, 5, binary trim-code width; must satisfy 2^CODE_W > TRIM_W
DIV_W, 5, width of div ratio input
CNT_W, 8, period counter width; must be > DIV_W
SYNC_STAGES, 3, osc synchroniser depth (>=2)
TOL, 0, allowed |error| in clocks counted as in-tolerance
ACQ_STEP, 4, code step per update in ACQUIRE
ACQ_THRESH, 2, |error| above which TRACK falls back to ACQUIRE
LOCK_COUNT, 8, consecutive in-tolerance updates needed to assert locked
INIT_CODE, 0, code loaded on reset and in IDLE

Ports:
clock  input  1  DCO clock (ring oscillator phase 0)
reset  input  1  asynchronous reset, active-high
enable  input  1  run controller; low forces IDLE
hold  input  1  freeze trim (HOLD state)
osc  input  1  asynchronous reference clock
div  input  DIV_W  target DCO cycles per osc period
trim  output  TRIM_W  thermometer trim, registered
code  output  CODE_W  binary trim code, registered
locked  output  1  lock indicator, registered
state  output  2  0=IDLE 1=ACQUIRE 2=TRACK 3=HOLD
osc_lost  output  1  reference-loss flag (see Optional Feature)

Behaviour:
- Reset: code=INIT_CODE, trim[i]=(i<INIT_CODE), locked=0, state=IDLE, osc_lost=0, counters 0, synchroniser cleared.
- osc passes through SYNC_STAGES flops. edge = last stage high and previous sample low (1-cycle pulse).
- Period counter cnt (CNT_W): on edge load 1, else increment, saturating at 2^CNT_W-1. measured = cnt on edge cycle. P clocks between edges gives measured=P.
- err = measured - div, signed CNT_W+1 bits.
- First edge after entering ACQUIRE from IDLE: discard the measurement, restart the count, no update.
- Updates occur only on edge cycles. code and trim are registered at the end of that cycle, so trim is visible on the next cycle. trim[i] = (i < code) always.
- err > TOL (DCO fast): code += step. err < -TOL (slow): code -= step. step = ACQ_STEP in ACQUIRE, 1 in TRACK. Result clamps to [0, TRIM_W] with no wrap.
- In-tolerance edge: code unchanged; lock_cnt increments, saturating at LOCK_COUNT; locked=1 when lock_cnt==LOCK_COUNT.
- Out-of-tolerance edge: lock_cnt=0, locked=0, same cycle as the code update.
- div==0: no code updates, locked forced 0, state unaffected.
- FSM:
  - IDLE: enable=1 -> ACQUIRE.
  - ACQUIRE: first in-tolerance edge -> TRACK.
  - TRACK: |err|>ACQ_THRESH -> ACQUIRE (also clears lock).
  - ACQUIRE/TRACK: hold=1 -> HOLD.
  - HOLD: code/trim/locked frozen, edges ignored, cnt keeps running; hold=0 -> TRACK.
  - enable=0 in any state -> IDLE next cycle: code=INIT_CODE, locked=0, lock_cnt=0. enable has priority over hold.
- Simultaneous hold rise and edge: hold wins, no update.
- Reset mid-operation: immediate asynchronous return to the reset values.

Optional Feature:
FLL_OSC_LOSS_EN
- Defined: cnt reaching saturation sets osc_lost=1, clears locked, and freezes code (no updates) until the next edge. That edge clears osc_lost and is discarded like a first edge.
- Undefined: osc_lost tied 0; a saturated cnt is used as measured normally.

Test Plan:
- Defaults, div=10, DCO/osc ratio 14, INIT_CODE=0 -> ACQUIRE, code steps 0,4,8... per edge while err>0, clamps at 26, never wraps.
- Ratio 11 with code settling: TOL=0 -> TRACK on first err=0 edge. Once the ratio equals 10, locked rises on the 8th consecutive in-tolerance edge, exactly 1 cycle after that edge.
- In TRACK with locked=1, ratio jumps to 13 (err=3>ACQ_THRESH) -> state=ACQUIRE, locked=0, next step size 4.
- hold=1 for 20 osc periods while ratio varies -> code/trim/locked constant, state=HOLD. hold=0 -> TRACK, updates resume at step 1.
- enable=0 mid-ACQUIRE with code=12 -> next cycle state=IDLE, code=0, trim=0. reset pulse asynchronously gives all outputs 0 without a clock.
- With FLL_OSC_LOSS_EN, stop osc for 300 clocks (CNT_W=8) -> osc_lost=1 at cnt=255, code frozen. Restart osc -> osc_lost=0, first measurement discarded.
